// File: rtl/aww_types_pkg.sv
// Shared pipeline types: register indices, stall status and sequencer state.
package aww_types_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned STALL_W    = 3;

  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef logic [REG_W-1:0]      regbits_t;

  typedef enum logic [STALL_W-1:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use comparator: an in-flight load targets a source of the decoding instruction.
module hazard_detect
  import aww_types_pkg::*;
(
  input  logic       idex_DataRead,
  input  logic [4:0] idex_wsel,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       lu_hazard
);

  // $0 is hardwired to zero, so a load into it never creates a dependency
  always_comb begin
    lu_hazard = idex_DataRead && (idex_wsel != regbits_t'(0)) &&
                ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush/halt controller for the five-stage pipeline.
module pipeline_sequencer
  import aww_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              exmem_mem_req,
  input  logic              exmem_Halt,
  input  logic              idex_DataRead,
  input  logic [4:0]        idex_wsel,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic              ex_redirect,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic [2:0]        stall,
  output logic              halt,
  output logic [WORD_W-1:0] stall_cycles
);

  seq_state_t  state, state_next;
  pipe_stall_t stall_sel;
  logic        lu_hazard;
  logic        dmem_wait;

  hazard_detect u_hazard_detect (
    .idex_DataRead (idex_DataRead),
    .idex_wsel     (idex_wsel),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .lu_hazard     (lu_hazard)
  );

  assign dmem_wait = exmem_mem_req && !dhit;
  assign stall     = 3'(stall_sel);

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  // Next-state: a halt reaching EX/MEM drains one cycle, then parks
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!dmem_wait && exmem_Halt) state_next = DRAIN;
      DRAIN:   state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // Enables, flushes and status; the RUN branch is an ordered priority chain
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    stall_sel   = FULL_STALL;
    if (nRST && state == RUN) begin
      if (dmem_wait) begin
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
        stall_sel   = EXMEM_STALL;
      end else if (exmem_Halt) begin
        memwb_en  = 1'b1;
        stall_sel = FULL_STALL;
      end else if (ex_redirect) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        stall_sel  = NO_STALL;
      end else if (lu_hazard) begin
        {idex_en, exmem_en, memwb_en} = '1;
        idex_flush = 1'b1;
        stall_sel  = IFID_STALL;
      end else if (!ihit) begin
        {ifid_en, idex_en, exmem_en, memwb_en} = '1;
        ifid_flush = 1'b1;
        stall_sel  = IFID_STALL;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        stall_sel = NO_STALL;
      end
    end
  end

  // Sticky halt, set as DRAIN hands over to HALTED
  always_ff @(posedge CLK) begin
    if (!nRST)              halt <= 1'b0;
    else if (state == DRAIN) halt <= 1'b1;
  end

  // Saturating count of RUN cycles in which the PC is held
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (state == RUN && !pc_en && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + WORD_W'(1);
    end
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush/halt controller for the five-stage pipeline. Each cycle it takes cache handshakes (ihit, dhit), hazard information from the IF/ID, ID/EX and EX/MEM latches, and branch resolution from EX. It drives the PC enable, the per-latch enables and flushes, the `pipe_stall_t` status and the registered halt. It sits beside the datapath and owns every pipeline-latch write decision.

## Interface
Parameters:
- `WORD_W`, 32, width of the stall-cycle counter (= `word_t`)

Ports:
- `CLK`  in  1  core clock
- `nRST`  in  1  reset, synchronous, active-low
- `ihit`  in  1  icache returned instruction this cycle
- `dhit`  in  1  dcache completed access this cycle
- `exmem_mem_req`  in  1  EX/MEM `DataRead | DataWrite`
- `exmem_Halt`  in  1  EX/MEM `Halt`
- `idex_DataRead`  in  1  ID/EX `DataRead`
- `idex_wsel`  in  5  ID/EX destination register (`regbits_t`)
- `ifid_rs`, `ifid_rt`  in  5 each  sources decoded from IF/ID `imemload`
- `ex_redirect`  in  1  EX resolved mispredict/jump/jr; PC mux selects target
- `pc_en`  out  1  PC register write
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  latch write enables
- `ifid_flush`, `idex_flush`, `memwb_flush`  out  1 each  latch loads bubble (flush wins over enable)
- `stall`  out  3  `pipe_stall_t` status
- `halt`  out  1  registered, sticky
- `stall_cycles`  out  WORD_W  saturating count of cycles with `pc_en`=0 in RUN

## Operation
- FSM `seq_state_t`: RUN, DRAIN, HALTED.
- RUN, combinational priority (first match wins):
  1. DMEM wait (`exmem_mem_req & !dhit`):
     - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` are 0.
     - `memwb_en`=1, `memwb_flush`=1.
     - `stall`=EXMEM_STALL.
  2. Halt (`exmem_Halt`):
     - Front enables 0; `memwb_en`=1.
     - Next state DRAIN; `stall`=FULL_STALL.
  3. Redirect (`ex_redirect`):
     - All enables 1.
     - `ifid_flush`=`idex_flush`=1.
     - `stall`=NO_STALL.
     - Redirect outranks load-use and imiss.
  4. Load-use (`idex_DataRead & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt)`):
     - `pc_en`=`ifid_en`=0.
     - `idex_flush`=1; other enables 1.
     - `stall`=IFID_STALL.
  5. Imiss (`!ihit`):
     - `pc_en`=0, `ifid_flush`=1; other enables 1.
     - `stall`=IFID_STALL.
  6. Otherwise:
     - All enables 1, flushes 0.
     - `stall`=NO_STALL.
- DRAIN (exactly one cycle):
  - All enables 0, flushes 0, so the halt commits out of MEM/WB.
  - `stall`=FULL_STALL.
  - Next state HALTED; `halt` is set at that edge.
- HALTED:
  - All enables and flushes 0; `stall`=FULL_STALL; `halt`=1.
  - `halt` is sticky until reset. All inputs are ignored.
- `stall_cycles`:
  - +1 on each RUN cycle with `pc_en`=0.
  - Saturates at all-ones; no wrap.
  - Frozen in DRAIN and HALTED.
- Register $0 is never a hazard: `idex_wsel`=0 suppresses load-use.

## Timing
- Sampled by reset: `nRST`=0 at a rising edge → state RUN, `halt`=0, `stall_cycles`=0.
- Combinational while `nRST`=0: all enables 0, flushes 0, `stall`=FULL_STALL.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- Enables and flushes are combinational from state and inputs, in the same cycle. Latches act at the following edge.
- Zero-cycle decision latency. Load-use costs exactly one bubble.
- A miss stalls until the hit arrives:
  - DMEM wait lasts N cycles for a `dhit` arriving N cycles later.
  - Imiss inserts one bubble per `!ihit` cycle.
- Simultaneous events:
  - DMEM wait + redirect: redirect is held and acts in the cycle `dhit` arrives. EX is frozen, so `ex_redirect` stays asserted.
  - Halt in EX/MEM + pending dmem: treated as DMEM wait first. Halts carry no mem op, so this cannot occur legally; the bench checks priority only.
  - Load-use + imiss: load-use outputs apply (IF/ID held, not flushed).

## Structure
- Add to `aww_types_pkg`: `seq_state_t` (logic [1:0] enum RUN/DRAIN/HALTED). `pipe_stall_t` is reused unchanged.
- Sub-module `hazard_detect`: combinational load-use comparator (`idex_DataRead`, `idex_wsel`, `ifid_rs`, `ifid_rt` → `lu_hazard`). It is instantiated once and reusable by the forwarding unit.
- Top module: FSM register, halt register, saturating counter, priority output logic.

## Test plan
- Reset: hold `nRST`=0 two cycles with all inputs 1 → enables 0, `stall`=FULL_STALL. After release with `ihit`=1 → all enables 1, `halt`=0, `stall_cycles`=0.
- Load-use: `idex_DataRead`=1, `idex_wsel`=5, `ifid_rt`=5 for one cycle → `pc_en`=`ifid_en`=0, `idex_flush`=1, `stall`=IFID_STALL, `stall_cycles`=1. Same with `idex_wsel`=0 → no stall.
- DMEM: `exmem_mem_req`=1, `dhit` low three cycles then high → three cycles of EXMEM_STALL with `memwb_flush`=1, then NO_STALL.
- Redirect during dmem wait: `ex_redirect`=1 and `exmem_mem_req`=1 with `dhit` low for 2 cycles → no flush for those two cycles; on the `dhit` cycle `ifid_flush`=`idex_flush`=1.
- Halt: `exmem_Halt`=1 for one cycle → DRAIN for one cycle, then `halt`=1 held for 10+ cycles with `ihit`/`ex_redirect` toggling. Pulsing `nRST` low clears `halt`.
- Saturation: force 2^WORD_W−1 counted stalls (or preload via a WORD_W=4 build: 20 imiss cycles) → `stall_cycles`=15, no wrap.
